// File: rtl/host_reset_sequencer.sv
// host_reset_sequencer
// Converts the software host-reset level and one-shot pulse strobe into a
// timed host reset sequence: a guaranteed minimum assertion, an optional hold
// while software keeps the request high, and a guard interval after release
// during which the cartridge bus stays disabled.
// Every output is registered from the current state, so outputs trail the
// state register by one cycle. The exception is the synchronous reset, which
// forces the outputs straight into their "host in reset" values.

module host_reset_sequencer #(
    parameter int MIN_ASSERT_CYCLES = 50000,
    parameter int GUARD_CYCLES      = 5000,
    parameter int CNT_W             = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reset_req,
    input  logic             pulse_req,
    output logic             host_reset_o,
    output logic             bus_enable,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] count_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2,
        ST_GUARD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(MIN_ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             doneArm_q;
    logic             doneArm_d;
    logic             hostReset_q;
    logic             busEnable_q;
    logic             busy_q;
    logic             done_q;

    logic             startReq;
    logic [CNT_W-1:0] countInc;

    // Either request form starts a sequence from IDLE or restarts it from GUARD.
    assign startReq = reset_req | pulse_req;

    // The phase counter saturates instead of wrapping; unreachable with legal parameters.
    assign countInc = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);

    // Next-state and counter logic; doneArm_d marks the GUARD to IDLE completion.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        doneArm_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (startReq) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (count_q == ASSERT_LAST) begin
                    state_d = reset_req ? ST_HOLD : ST_GUARD;
                    count_d = '0;
                end else begin
                    count_d = countInc;
                end
            end
            ST_HOLD: begin
                count_d = '0;
                if (!reset_req) begin
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (startReq) begin
                    state_d = ST_ASSERT;
                    count_d = '0;
                end else if (count_q == GUARD_LAST) begin
                    state_d   = ST_IDLE;
                    count_d   = '0;
                    doneArm_d = 1'b1;
                end else begin
                    count_d = countInc;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                count_d = '0;
            end
        endcase
    end

    // State, counter and registered outputs; outputs follow the state register one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ASSERT;
            count_q     <= '0;
            doneArm_q   <= 1'b0;
            hostReset_q <= 1'b1;
            busEnable_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            doneArm_q   <= doneArm_d;
            hostReset_q <= (state_q == ST_ASSERT) || (state_q == ST_HOLD);
            busEnable_q <= (state_q == ST_IDLE);
            busy_q      <= (state_q != ST_IDLE);
            done_q      <= doneArm_q;
        end
    end

    assign host_reset_o = hostReset_q;
    assign bus_enable   = busEnable_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign state_o      = state_q;
    assign count_o      = count_q;

endmodule
